// File: rtl/rx_param_funcmod.sv
// Parametrised UART receiver: 2-flop RXD synchroniser, false-start rejection, framing/parity flags.
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit (even, or odd with PARITY_ODD=1).
module rx_param_funcmod #(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              RXD,
  input  logic              iCall,
  output logic              oDone,
  output logic [DATA_W-1:0] oData,
  output logic              oFrameErr,
  output logic              oParityErr
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int IDX_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (BAUD_DIV < 8) begin : g_bad_baud
    $error("rx_param_funcmod: BAUD_DIV must be >= 8");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("rx_param_funcmod: DATA_W must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("rx_param_funcmod: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("rx_param_funcmod: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_DONE
  } state_t;

  // RXD is asynchronous; both flops idle high so reset never looks like a start bit.
  logic sync_meta_reg;
  logic sync_reg;
  logic rxs;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync_meta_reg <= 1'b1;
      sync_reg      <= 1'b1;
    end else begin
      sync_meta_reg <= RXD;
      sync_reg      <= sync_meta_reg;
    end
  end

  assign rxs = sync_reg;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic                ferr_acc_reg, ferr_acc_next;
  logic                done_reg, done_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic                perr_acc_reg, perr_acc_next;
  logic                parity_err_reg, parity_err_next;
`endif
  logic                bit_tick;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      ferr_acc_reg   <= 1'b0;
      done_reg       <= 1'b0;
      data_reg       <= '0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_acc_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shift_reg      <= shift_next;
      ferr_acc_reg   <= ferr_acc_next;
      done_reg       <= done_next;
      data_reg       <= data_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      perr_acc_reg   <= perr_acc_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign bit_tick = (cnt_reg == BIT_LAST);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    shift_next      = shift_reg;
    ferr_acc_next   = ferr_acc_reg;
    done_next       = 1'b0;
    data_next       = data_reg;
    frame_err_next  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    perr_acc_next   = perr_acc_reg;
    parity_err_next = parity_err_reg;
`endif

    if (!iCall && state_reg != ST_IDLE) begin
      // Abort: drop the partial frame, published outputs stay as they were.
      state_next = ST_IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (iCall && !rxs) begin
            state_next    = ST_START;
            cnt_next      = '0;
            idx_next      = '0;
            ferr_acc_next = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc_next = 1'b0;
`endif
          end
        end

        ST_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_next   = '0;
            state_next = rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        ST_DATA: begin
          if (bit_tick) begin
            cnt_next   = '0;
            // Shift in at the top so the first (LSB) bit ends up in bit 0.
            shift_next = {rxs, shift_reg[DATA_W-1:1]};
            if (idx_reg == DATA_LAST) begin
              idx_next = '0;
`ifdef UART_RX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            cnt_next      = '0;
            perr_acc_next = rxs ^ (^shift_reg) ^ (PARITY_ODD != 0);
            state_next    = ST_STOP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (bit_tick) begin
            cnt_next = '0;
            if (!rxs) begin
              ferr_acc_next = 1'b1;
            end
            if (idx_reg == STOP_LAST) begin
              idx_next   = '0;
              state_next = ST_DONE;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        ST_DONE: begin
          done_next       = 1'b1;
          data_next       = shift_reg;
          frame_err_next  = ferr_acc_reg;
`ifdef UART_RX_PARITY_EN
          parity_err_next = perr_acc_reg;
`endif
          state_next      = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  assign oDone     = done_reg;
  assign oData     = data_reg;
  assign oFrameErr = frame_err_reg;
`ifdef UART_RX_PARITY_EN
  assign oParityErr = parity_err_reg;
`else
  assign oParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_rx_param_funcmod.sv
// Directed bench for rx_param_funcmod: default 8N1/434 instance (a) and a 7-bit, 2-stop, 16 clk/bit instance (b).
module tb_rx_param_funcmod;

`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int A_DIV  = 434;
  localparam int A_W    = 8;
  localparam int A_STOP = 1;
  // Edges from driving the start bit to oDone visible: 2 sync + 1 detect + half bit + frame + 1 (4127 without parity).
  localparam int A_LAT  = 4 + A_DIV / 2 + (A_W + P + A_STOP) * A_DIV;
  localparam int B_DIV  = 16;
  localparam int B_W    = 7;
  localparam int B_STOP = 2;
  localparam int B_LAT  = 4 + B_DIV / 2 + (B_W + P + B_STOP) * B_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a = 1'b0, rxd_a = 1'b1, icall_a = 1'b0;
  logic       done_a, ferr_a, perr_a;
  logic [7:0] data_a;
  logic       rst_n_b = 1'b0, rxd_b = 1'b1, icall_b = 1'b0;
  logic       done_b, ferr_b, perr_b;
  logic [6:0] data_b;

  rx_param_funcmod u_dut_a (
    .CLOCK(clk), .RESET(rst_n_a), .RXD(rxd_a), .iCall(icall_a),
    .oDone(done_a), .oData(data_a), .oFrameErr(ferr_a), .oParityErr(perr_a)
  );

  rx_param_funcmod #(.BAUD_DIV(B_DIV), .DATA_W(B_W), .STOP_BITS(B_STOP), .PARITY_ODD(0)) u_dut_b (
    .CLOCK(clk), .RESET(rst_n_b), .RXD(rxd_b), .iCall(icall_b),
    .oDone(done_b), .oData(data_b), .oFrameErr(ferr_b), .oParityErr(perr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int         cnt_a = 0, last_cyc_a = 0;
  logic [7:0] last_data_a = '0;
  logic       last_ferr_a = 1'b0, last_perr_a = 1'b0;
  int         cnt_b = 0, last_cyc_b = 0;
  logic [6:0] last_data_b = '0;
  logic       last_ferr_b = 1'b0, last_perr_b = 1'b0;

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      cnt_a       <= cnt_a + 1;
      last_cyc_a  <= cyc;
      last_data_a <= data_a;
      last_ferr_a <= ferr_a;
      last_perr_a <= perr_a;
    end
    if (done_b === 1'b1) begin
      cnt_b       <= cnt_b + 1;
      last_cyc_b  <= cyc;
      last_data_b <= data_b;
      last_ferr_b <= ferr_b;
      last_perr_b <= perr_b;
    end
  end

  task automatic put_bit(input int which, input logic v, input int div);
    if (which == 0) rxd_a = v; else rxd_b = v;
    repeat (div) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge ending the last stop bit with the line high.
  task automatic send_frame(input int which, input logic [8:0] data, input logic stop_val,
                            input logic par_flip, output int t0);
    int   w, div, stops;
    logic par;
    w     = (which == 0) ? A_W : B_W;
    div   = (which == 0) ? A_DIV : B_DIV;
    stops = (which == 0) ? A_STOP : B_STOP;
    par   = par_flip;
    for (int i = 0; i < w; i++) par ^= data[i];
    t0 = cyc;
    put_bit(which, 1'b0, div);
    for (int i = 0; i < w; i++) put_bit(which, data[i], div);
    if (P == 1) put_bit(which, par, div);
    for (int i = 0; i < stops; i++) put_bit(which, stop_val, div);
    if (which == 0) rxd_a = 1'b1; else rxd_b = 1'b1;
    $display("frame %s data=0x%0h stop=%0b par_flip=%0b start_cycle=%0d",
             (which == 0) ? "a" : "b", data, stop_val, par_flip, t0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({done_a, data_a, ferr_a, perr_a} !== 11'd0) begin
      n_bad++; $display("FAIL reset_a: got %b want 0", {done_a, data_a, ferr_a, perr_a});
    end
    n_cmp++;
    if ({done_b, data_b, ferr_b, perr_b} !== 10'd0) begin
      n_bad++; $display("FAIL reset_b: got %b want 0", {done_b, data_b, ferr_b, perr_b});
    end
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    icall_a = 1'b1; icall_b = 1'b1;
    idle(5);
    n_cmp++;
    if (cnt_a + cnt_b !== 0) begin
      n_bad++; $display("FAIL reset_no_done: got %0d pulses want 0", cnt_a + cnt_b);
    end
  endtask

  task automatic test_basic;
    int t0, c0;
    c0 = cnt_a;
    send_frame(0, 9'h0AB, 1'b1, 1'b0, t0);
    n_cmp++; if (cnt_a - c0 !== 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", cnt_a - c0); end
    n_cmp++; if (last_data_a !== 8'hAB) begin n_bad++; $display("FAIL basic_data: got %h want ab", last_data_a); end
    n_cmp++; if (last_ferr_a !== 1'b0) begin n_bad++; $display("FAIL basic_ferr: got %b want 0", last_ferr_a); end
    n_cmp++; if (last_perr_a !== 1'b0) begin n_bad++; $display("FAIL basic_perr: got %b want 0", last_perr_a); end
    n_cmp++;
    if (last_cyc_a !== t0 + A_LAT) begin
      n_bad++; $display("FAIL basic_latency: got %0d want %0d", last_cyc_a - t0, A_LAT);
    end
    n_cmp++; if (data_a !== 8'hAB) begin n_bad++; $display("FAIL basic_hold: got %h want ab", data_a); end
    idle(A_DIV);
  endtask

  task automatic test_frame_error;
    int t0, c0;
    c0 = cnt_a;
    send_frame(0, 9'h03C, 1'b0, 1'b0, t0);
    n_cmp++; if (cnt_a - c0 !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", cnt_a - c0); end
    n_cmp++; if (last_data_a !== 8'h3C) begin n_bad++; $display("FAIL ferr_data: got %h want 3c", last_data_a); end
    n_cmp++; if (last_ferr_a !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", last_ferr_a); end
    idle(A_DIV);
    n_cmp++; if (cnt_a - c0 !== 1) begin n_bad++; $display("FAIL ferr_recover: got %0d want 1", cnt_a - c0); end
    send_frame(0, 9'h001, 1'b1, 1'b0, t0);
    n_cmp++; if (cnt_a - c0 !== 2) begin n_bad++; $display("FAIL ferr_next_count: got %0d want 2", cnt_a - c0); end
    n_cmp++; if (last_data_a !== 8'h01) begin n_bad++; $display("FAIL ferr_next_data: got %h want 01", last_data_a); end
    n_cmp++; if (last_ferr_a !== 1'b0) begin n_bad++; $display("FAIL ferr_next_flag: got %b want 0", last_ferr_a); end
    idle(A_DIV);
  endtask

  task automatic test_false_start;
    int t0, c0;
    c0 = cnt_a;
    rxd_a = 1'b0;
    idle(100);
    rxd_a = 1'b1;
    $display("glitch a low for 100 cycles");
    idle(2 * A_DIV);
    n_cmp++; if (cnt_a - c0 !== 0) begin n_bad++; $display("FAIL false_start: got %0d pulses want 0", cnt_a - c0); end
    send_frame(0, 9'h05A, 1'b1, 1'b0, t0);
    n_cmp++; if (cnt_a - c0 !== 1) begin n_bad++; $display("FAIL fs_next_count: got %0d want 1", cnt_a - c0); end
    n_cmp++; if (last_data_a !== 8'h5A) begin n_bad++; $display("FAIL fs_next_data: got %h want 5a", last_data_a); end
    n_cmp++;
    if (last_cyc_a !== t0 + A_LAT) begin
      n_bad++; $display("FAIL fs_next_latency: got %0d want %0d", last_cyc_a - t0, A_LAT);
    end
    idle(A_DIV);
  endtask

  task automatic test_back_to_back;
    int t0, t1, c0;
    c0 = cnt_a;
    send_frame(0, 9'h055, 1'b1, 1'b0, t0);
    n_cmp++; if (last_data_a !== 8'h55) begin n_bad++; $display("FAIL b2b_first: got %h want 55", last_data_a); end
    send_frame(0, 9'h0A3, 1'b1, 1'b0, t1);
    n_cmp++; if (cnt_a - c0 !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", cnt_a - c0); end
    n_cmp++; if (last_data_a !== 8'hA3) begin n_bad++; $display("FAIL b2b_second: got %h want a3", last_data_a); end
    n_cmp++;
    if (last_cyc_a !== t1 + A_LAT) begin
      n_bad++; $display("FAIL b2b_latency: got %0d want %0d", last_cyc_a - t1, A_LAT);
    end
    idle(A_DIV);

    c0 = cnt_a;
    send_frame(0, 9'h055, 1'b1, 1'b0, t0);
    fork
      send_frame(0, 9'h0A3, 1'b1, 1'b0, t1);
      begin
        idle(3 * A_DIV);
        icall_a = 1'b0;
        $display("abort a at cycle %0d", cyc);
      end
    join
    idle(4);
    icall_a = 1'b1;
    idle(A_DIV);
    n_cmp++; if (cnt_a - c0 !== 1) begin n_bad++; $display("FAIL abort_count: got %0d want 1", cnt_a - c0); end
    n_cmp++; if (data_a !== 8'h55) begin n_bad++; $display("FAIL abort_hold: got %h want 55", data_a); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int t0, c0;
    c0 = cnt_a;
    send_frame(0, 9'h0AB, 1'b1, 1'b0, t0);
    n_cmp++; if (last_perr_a !== 1'b0) begin n_bad++; $display("FAIL parity_good: got %b want 0", last_perr_a); end
    idle(A_DIV);
    send_frame(0, 9'h0AB, 1'b1, 1'b1, t0);
    n_cmp++; if (cnt_a - c0 !== 2) begin n_bad++; $display("FAIL parity_count: got %0d want 2", cnt_a - c0); end
    n_cmp++; if (last_perr_a !== 1'b1) begin n_bad++; $display("FAIL parity_bad: got %b want 1", last_perr_a); end
    n_cmp++; if (last_data_a !== 8'hAB) begin n_bad++; $display("FAIL parity_data: got %h want ab", last_data_a); end
    idle(A_DIV);
  endtask
`endif

  task automatic test_reset_midframe;
    int t0, c0;
    c0 = cnt_b;
    send_frame(1, 9'h041, 1'b1, 1'b0, t0);
    n_cmp++; if (cnt_b - c0 !== 1) begin n_bad++; $display("FAIL b_count: got %0d want 1", cnt_b - c0); end
    n_cmp++; if (last_data_b !== 7'h41) begin n_bad++; $display("FAIL b_data: got %h want 41", last_data_b); end
    n_cmp++;
    if (last_cyc_b !== t0 + B_LAT) begin
      n_bad++; $display("FAIL b_latency: got %0d want %0d", last_cyc_b - t0, B_LAT);
    end
    idle(2 * B_DIV);
    c0 = cnt_b;
    fork
      send_frame(1, 9'h041, 1'b1, 1'b0, t0);
      begin
        idle(3 * B_DIV);
        rst_n_b = 1'b0;
        $display("reset b asserted at cycle %0d", cyc);
        idle(2);
        n_cmp++;
        if ({done_b, data_b, ferr_b, perr_b} !== 10'd0) begin
          n_bad++; $display("FAIL b_mid_reset: got %b want 0", {done_b, data_b, ferr_b, perr_b});
        end
      end
    join
    rst_n_b = 1'b1;
    idle(2 * B_DIV);
    n_cmp++; if (cnt_b - c0 !== 0) begin n_bad++; $display("FAIL b_partial: got %0d pulses want 0", cnt_b - c0); end
    send_frame(1, 9'h041, 1'b1, 1'b0, t0);
    idle(B_DIV);
    n_cmp++; if (cnt_b - c0 !== 1) begin n_bad++; $display("FAIL b_resend_count: got %0d want 1", cnt_b - c0); end
    n_cmp++; if (last_data_b !== 7'h41) begin n_bad++; $display("FAIL b_resend_data: got %h want 41", last_data_b); end
    n_cmp++; if (last_ferr_b !== 1'b0) begin n_bad++; $display("FAIL b_resend_ferr: got %b want 0", last_ferr_b); end
    n_cmp++;
    if (last_cyc_b !== t0 + B_LAT) begin
      n_bad++; $display("FAIL b_resend_latency: got %0d want %0d", last_cyc_b - t0, B_LAT);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_frame_error;
    test_false_start;
    test_back_to_back;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
